// File: rtl/solitaire_pkg.sv
// Shared solitaire card encoding, pile codes, slot counts and the auto-mover FSM state type.
// Card layout: rank [6:3] (0=ace..12=king), suit [2:1], visible [0]; all-zero means an empty slot.
package solitaire_pkg;

  localparam int CARD_W   = 7;
  localparam int RANK_LSB = 3;
  localparam int SUIT_LSB = 1;
  localparam int VIS_BIT  = 0;

  localparam logic [CARD_W-1:0] CARD_EMPTY = 7'b0;

  localparam logic [1:0] SUIT_HEARTS   = 2'b00;
  localparam logic [1:0] SUIT_CLUBS    = 2'b01;
  localparam logic [1:0] SUIT_DIAMONDS = 2'b10;
  localparam logic [1:0] SUIT_SPADES   = 2'b11;

  localparam logic [3:0] RANK_KING = 4'd12;

  localparam logic [3:0] PILE_TALON      = 4'd0;
  localparam logic [3:0] PILE_FOUNDATION = 4'd8;

  localparam int TALON_SLOTS      = 24;
  localparam int TABLEAU_SLOTS    = 19;
  localparam int FOUNDATION_SLOTS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } mover_state_e;

  // True when card may be placed on its suit's foundation slot.
  function automatic logic can_play(input logic [CARD_W-1:0] card,
                                    input logic [FOUNDATION_SLOTS*CARD_W-1:0] fnd);
    logic [CARD_W-1:0] slot;
    logic [3:0]        rank;
    logic [3:0]        base;
    slot = CARD_EMPTY;
    case (card[SUIT_LSB +: 2])
      SUIT_HEARTS:   slot = fnd[27:21];
      SUIT_CLUBS:    slot = fnd[20:14];
      SUIT_DIAMONDS: slot = fnd[13:7];
      SUIT_SPADES:   slot = fnd[6:0];
    endcase
    rank = card[RANK_LSB +: 4];
    base = slot[RANK_LSB +: 4];
    if (slot == CARD_EMPTY) begin
      return rank == 4'd0;
    end else if (base >= RANK_KING) begin
      return 1'b0;
    end else begin
      return rank == base + 4'd1;
    end
  endfunction

endpackage

// File: rtl/foundation_auto_mover_if.sv
// Move-request channel shared with inputOutput/moveCard: request fields plus the responder's completion.
interface foundation_auto_mover_if;
  logic [3:0] source;
  logic [3:0] source_offset;
  logic [3:0] destination;
  logic       input_ready;
  logic       move_ready;
  logic       successful;

  modport master (
    output source, source_offset, destination, input_ready,
    input  move_ready, successful
  );

  modport slave (
    input  source, source_offset, destination, input_ready,
    output move_ready, successful
  );
endinterface

// File: rtl/pile_top_finder.sv
// Combinational priority scan returning the highest-index non-empty slot of a pile.
module pile_top_finder
  import solitaire_pkg::*;
#(
  parameter int SLOTS = 19
) (
  input  logic [SLOTS*CARD_W-1:0] pile,
  output logic [CARD_W-1:0]       top_card,
  output logic                    empty
);

  always_comb begin
    top_card = CARD_EMPTY;
    empty    = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      if (pile[i*CARD_W +: CARD_W] != CARD_EMPTY) begin
        top_card = pile[i*CARD_W +: CARD_W];
        empty    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/foundation_auto_mover.sv
// Scans talon and tableau tops and issues foundation moves until none remain.
// Optional WAIT-state watchdog enabled by defining AUTO_MOVE_TIMEOUT_EN.
module foundation_auto_mover
  import solitaire_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_MOVES      = 52
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [TALON_SLOTS*CARD_W-1:0]         talon_pile,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau1,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau2,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau3,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau4,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau5,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau6,
  input  logic [TABLEAU_SLOTS*CARD_W-1:0]       tableau7,
  input  logic [FOUNDATION_SLOTS*CARD_W-1:0]    foundation_cards,
  foundation_auto_mover_if.master               mv,
  output logic                                  busy,
  output logic                                  done,
  output logic [5:0]                            move_count,
  output logic                                  timeout_err
);

  logic [TABLEAU_SLOTS*CARD_W-1:0] tableau_piles [7];
  logic [CARD_W-1:0]               pile_tops     [8];
  logic                            pile_empty    [8];

  assign tableau_piles[0] = tableau1;
  assign tableau_piles[1] = tableau2;
  assign tableau_piles[2] = tableau3;
  assign tableau_piles[3] = tableau4;
  assign tableau_piles[4] = tableau5;
  assign tableau_piles[5] = tableau6;
  assign tableau_piles[6] = tableau7;

  pile_top_finder #(.SLOTS(TALON_SLOTS)) u_talon_top (
    .pile     (talon_pile),
    .top_card (pile_tops[0]),
    .empty    (pile_empty[0])
  );

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_tableau_top
      pile_top_finder #(.SLOTS(TABLEAU_SLOTS)) u_top (
        .pile     (tableau_piles[gi]),
        .top_card (pile_tops[gi+1]),
        .empty    (pile_empty[gi+1])
      );
    end
  endgenerate

  mover_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [3:0]   source_q, source_d;
  logic [5:0]   move_count_q, move_count_d;
  logic         scan_legal;

  // Pile code equals scan index: 0 talon, 1..7 tableau.
  assign scan_legal = !pile_empty[idx_q] && pile_tops[idx_q][VIS_BIT]
                      && can_play(pile_tops[idx_q], foundation_cards);

`ifdef AUTO_MOVE_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    source_d     = source_q;
    move_count_d = move_count_q;
`ifdef AUTO_MOVE_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          move_count_d = 6'd0;
          idx_d        = 3'd0;
          state_d      = ST_SCAN;
`ifdef AUTO_MOVE_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (scan_legal) begin
          source_d = {1'b0, idx_q};
          state_d  = ST_ISSUE;
        end else if (idx_q != 3'd7) begin
          idx_d = idx_q + 3'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef AUTO_MOVE_TIMEOUT_EN
        wait_cnt_d = 8'd0;
`endif
      end
      ST_WAIT: begin
        if (mv.move_ready) begin
          if (mv.successful) begin
            if (move_count_q != 6'(MAX_MOVES)) begin
              move_count_d = move_count_q + 6'd1;
            end
            if (move_count_q + 6'd1 >= 6'(MAX_MOVES)) begin
              state_d = ST_DONE;
            end else begin
              // A successful move changes the board, so every pile is re-examined.
              idx_d   = 3'd0;
              state_d = ST_SCAN;
            end
          end else if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end
`ifdef AUTO_MOVE_TIMEOUT_EN
        else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      source_q     <= PILE_TALON;
      move_count_q <= 6'd0;
`ifdef AUTO_MOVE_TIMEOUT_EN
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      source_q     <= source_d;
      move_count_q <= move_count_d;
`ifdef AUTO_MOVE_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign mv.source        = source_q;
  assign mv.source_offset = 4'd0;
  assign mv.destination   = PILE_FOUNDATION;
  assign mv.input_ready   = (state_q == ST_ISSUE);
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign move_count       = move_count_q;

`ifdef AUTO_MOVE_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_foundation_auto_mover.sv
// Directed bench for foundation_auto_mover: vector table of single passes plus multi-cycle sequences.
module tb_foundation_auto_mover;
  import solitaire_pkg::*;

`ifdef AUTO_MOVE_TIMEOUT_EN
  localparam int TB_TIMEOUT = 10;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [167:0] talon_pile;
  logic [132:0] tableau1, tableau2, tableau3, tableau4, tableau5, tableau6, tableau7;
  logic [27:0]  foundation_cards;
  logic         busy, done, timeout_err;
  logic [5:0]   move_count;

  foundation_auto_mover_if mv();

  always #5 clk = ~clk;

  foundation_auto_mover #(.TIMEOUT_CYCLES(TB_TIMEOUT), .MAX_MOVES(52)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .talon_pile       (talon_pile),
    .tableau1         (tableau1),
    .tableau2         (tableau2),
    .tableau3         (tableau3),
    .tableau4         (tableau4),
    .tableau5         (tableau5),
    .tableau6         (tableau6),
    .tableau7         (tableau7),
    .foundation_cards (foundation_cards),
    .mv               (mv),
    .busy             (busy),
    .done             (done),
    .move_count       (move_count),
    .timeout_err      (timeout_err)
  );

  typedef struct {
    logic [167:0]      talon;
    logic [6:0][132:0] tab;
    logic [27:0]       fnd;
    int                exp_src;
    int                exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] mk(input int rank, input int suit, input int vis);
    return {rank[3:0], suit[1:0], vis[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    talon_pile = '0;
    tableau1 = '0; tableau2 = '0; tableau3 = '0; tableau4 = '0;
    tableau5 = '0; tableau6 = '0; tableau7 = '0;
    foundation_cards = '0;
  endtask

  // kind: 0 nothing within budget, 1 request seen, 2 done seen; cyc counts cycles stepped.
  task automatic wait_event(output int kind, output int cyc);
    kind = 0;
    cyc  = 0;
    repeat (60) begin
      step();
      cyc++;
      start         = 1'b0;
      mv.move_ready = 1'b0;
      mv.successful = 1'b0;
      if (mv.input_ready) begin
        kind = 1;
        return;
      end
      if (done) begin
        kind = 2;
        return;
      end
    end
  endtask

  // Called in the ISSUE cycle; leaves the response presented in the second WAIT cycle.
  task automatic respond(input logic ok);
    step();
    chk("ir_single_pulse", mv.input_ready, 1'b0);
    step();
    mv.move_ready = 1'b1;
    mv.successful = ok;
  endtask

  vec_t vecs[6];
  int   kind, cyc, guard;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mv.move_ready = 1'b0;
    mv.successful = 1'b0;
    clear_board();

    for (int i = 0; i < 6; i++) begin
      vecs[i].talon = '0;
      vecs[i].tab   = '0;
      vecs[i].fnd   = '0;
    end
    vecs[0].tab[2][6:0] = mk(0, 0, 1);
    vecs[0].exp_src = 3; vecs[0].exp_lat = 5;
    vecs[1].talon[6:0]   = mk(9, 1, 0);
    vecs[1].talon[41:35] = mk(1, 3, 1);
    vecs[1].fnd[6:0]     = mk(0, 3, 1);
    vecs[1].exp_src = 0; vecs[1].exp_lat = 2;
    vecs[2].tab[0][6:0] = 7'b0101000;
    vecs[2].exp_src = -1; vecs[2].exp_lat = 9;
    for (int s = 0; s < 18; s++) vecs[3].tab[6][s*7 +: 7] = mk(5, 2, 0);
    vecs[3].tab[6][132:126] = mk(0, 1, 1);
    vecs[3].exp_src = 7; vecs[3].exp_lat = 9;
    vecs[4].fnd[27:21]  = mk(12, 0, 1);
    vecs[4].fnd[13:7]   = mk(5, 2, 1);
    vecs[4].tab[0][6:0] = mk(13, 0, 1);
    vecs[4].tab[1][6:0] = mk(7, 2, 1);
    vecs[4].tab[3][6:0] = mk(6, 2, 1);
    vecs[4].exp_src = 4; vecs[4].exp_lat = 6;
    vecs[5].fnd[27:21]    = mk(0, 0, 1);
    vecs[5].talon[6:0]    = mk(2, 0, 1);
    vecs[5].tab[5][6:0]   = mk(0, 3, 1);
    vecs[5].tab[5][20:14] = mk(5, 3, 0);
    vecs[5].tab[4][6:0]   = mk(1, 1, 1);
    vecs[5].exp_src = -1; vecs[5].exp_lat = 9;

    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_input_ready", mv.input_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_source", mv.source, 4'd0);
    chk("rst_offset", mv.source_offset, 4'd0);
    chk("rst_destination", mv.destination, 4'd8);
    chk("rst_move_count", move_count, 6'd0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst = 1'b1;
    step();

    // Table-driven single passes; every request is refused so the pass runs to DONE.
    for (int i = 0; i < 6; i++) begin
      talon_pile = vecs[i].talon;
      tableau1 = vecs[i].tab[0]; tableau2 = vecs[i].tab[1]; tableau3 = vecs[i].tab[2];
      tableau4 = vecs[i].tab[3]; tableau5 = vecs[i].tab[4]; tableau6 = vecs[i].tab[5];
      tableau7 = vecs[i].tab[6];
      foundation_cards = vecs[i].fnd;
      start = 1'b1;
      wait_event(kind, cyc);
      if (vecs[i].exp_src >= 0) begin
        chk($sformatf("v%0d_kind", i), kind, 1);
        chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
        chk($sformatf("v%0d_source", i), mv.source, vecs[i].exp_src);
        chk($sformatf("v%0d_offset", i), mv.source_offset, 0);
        chk($sformatf("v%0d_destination", i), mv.destination, 8);
        guard = 0;
        while (kind == 1 && guard < 10) begin
          respond(1'b0);
          wait_event(kind, cyc);
          guard++;
        end
        chk($sformatf("v%0d_end_done", i), kind, 2);
      end else begin
        chk($sformatf("v%0d_kind", i), kind, 2);
        chk($sformatf("v%0d_done_latency", i), cyc, vecs[i].exp_lat);
      end
      chk($sformatf("v%0d_move_count", i), move_count, 0);
      chk($sformatf("v%0d_timeout_err", i), timeout_err, 0);
      step();
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_busy_after", i), busy, 0);
      $display("vector %0d: event=%0d cyc=%0d source=%0d move_count=%0d", i, kind, cyc, mv.source, move_count);
    end

    // Successful move forces a rescan from the talon.
    clear_board();
    tableau3[6:0] = mk(0, 0, 1);
    start = 1'b1;
    wait_event(kind, cyc);
    chk("A_kind", kind, 1);
    chk("A_source", mv.source, 3);
    tableau3 = '0;
    foundation_cards[27:21] = mk(0, 0, 1);
    tableau1[6:0] = mk(1, 0, 1);
    respond(1'b1);
    wait_event(kind, cyc);
    chk("A_rescan_kind", kind, 1);
    chk("A_rescan_latency", cyc, 3);
    chk("A_rescan_source", mv.source, 1);
    chk("A_count1", move_count, 1);
    tableau1 = '0;
    foundation_cards[27:21] = mk(1, 0, 1);
    respond(1'b1);
    wait_event(kind, cyc);
    chk("A_done_kind", kind, 2);
    chk("A_done_latency", cyc, 9);
    chk("A_count2", move_count, 2);
    $display("seq A: source=%0d move_count=%0d", mv.source, move_count);
    step();

    // Refusal resumes at next pile; start during WAIT and move_ready during ISSUE are ignored.
    clear_board();
    tableau2[6:0] = mk(0, 1, 1);
    tableau3[6:0] = mk(0, 2, 1);
    start = 1'b1;
    wait_event(kind, cyc);
    chk("B_kind", kind, 1);
    chk("B_latency", cyc, 4);
    chk("B_source", mv.source, 2);
    mv.move_ready = 1'b1;
    mv.successful = 1'b1;
    step();
    mv.move_ready = 1'b0;
    mv.successful = 1'b0;
    start = 1'b1;
    chk("B_wait_ir", mv.input_ready, 0);
    chk("B_wait_busy", busy, 1);
    step();
    start = 1'b0;
    chk("B_issue_resp_ignored", move_count, 0);
    chk("B_wait_ir2", mv.input_ready, 0);
    step();
    chk("B_start_ignored_busy", busy, 1);
    chk("B_start_ignored_ir", mv.input_ready, 0);
    chk("B_source_stable", mv.source, 2);
    mv.move_ready = 1'b1;
    mv.successful = 1'b0;
    wait_event(kind, cyc);
    chk("B_next_kind", kind, 1);
    chk("B_next_latency", cyc, 2);
    chk("B_next_source", mv.source, 3);
    respond(1'b0);
    wait_event(kind, cyc);
    chk("B_done_kind", kind, 2);
    chk("B_done_latency", cyc, 5);
    chk("B_count", move_count, 0);
    $display("seq B: source=%0d move_count=%0d", mv.source, move_count);
    step();

    // Reset mid-WAIT drops the pending move; a late response does nothing.
    clear_board();
    tableau5[6:0] = mk(0, 3, 1);
    start = 1'b1;
    wait_event(kind, cyc);
    chk("C_kind", kind, 1);
    tableau5[6:0] = mk(1, 3, 1);
    foundation_cards[6:0] = mk(0, 3, 1);
    respond(1'b1);
    wait_event(kind, cyc);
    chk("C_second_latency", cyc, 7);
    chk("C_second_source", mv.source, 5);
    chk("C_count1", move_count, 1);
    step();
    rst = 1'b0;
    step();
    chk("C_rst_busy", busy, 0);
    chk("C_rst_ir", mv.input_ready, 0);
    chk("C_rst_source", mv.source, 0);
    chk("C_rst_count", move_count, 0);
    chk("C_rst_done", done, 0);
    rst = 1'b1;
    mv.move_ready = 1'b1;
    mv.successful = 1'b1;
    step();
    mv.move_ready = 1'b0;
    mv.successful = 1'b0;
    repeat (3) step();
    chk("C_late_resp_busy", busy, 0);
    chk("C_late_resp_count", move_count, 0);
    chk("C_late_resp_ir", mv.input_ready, 0);
    $display("seq C: busy=%0d move_count=%0d", busy, move_count);

    // Pass stops after MAX_MOVES successful moves.
    clear_board();
    tableau1[6:0] = mk(0, 0, 1);
    start = 1'b1;
    for (int m = 0; m < 52; m++) begin
      wait_event(kind, cyc);
      if (kind != 1) begin
        chk($sformatf("D_req%0d", m), kind, 1);
        break;
      end
      respond(1'b1);
    end
    wait_event(kind, cyc);
    chk("D_done_kind", kind, 2);
    chk("D_done_latency", cyc, 1);
    chk("D_count_max", move_count, 52);
    $display("seq D: move_count=%0d", move_count);
    step();
    chk("D_count_hold", move_count, 52);

`ifdef AUTO_MOVE_TIMEOUT_EN
    // Unanswered request aborts after the WAIT budget.
    clear_board();
    tableau1[6:0] = mk(0, 0, 1);
    start = 1'b1;
    wait_event(kind, cyc);
    chk("E_kind", kind, 1);
    step();
    cyc = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      cyc = n;
      if (done) break;
    end
    chk("E_done", done, 1);
    chk("E_timeout_latency", cyc, 10);
    chk("E_timeout_err", timeout_err, 1);
    step();
    chk("E_timeout_sticky", timeout_err, 1);
    clear_board();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("E_timeout_cleared", timeout_err, 0);
    $display("seq E: timeout latency=%0d", cyc);
    repeat (10) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
